// File: rtl/video_stream_monitor_if.sv
// Display stream bundle between the video output stage (master) and the stream monitor (slave).
interface video_stream_monitor_if;
    logic       frame_valid;
    logic       line_valid;
    logic [7:0] pixel_in;

    modport master (output frame_valid, output line_valid, output pixel_in);
    modport slave  (input  frame_valid, input  line_valid, input  pixel_in);
endinterface

// File: rtl/video_stream_monitor.sv
// Display-path self-test monitor: checks frame geometry and computes a per-frame Fletcher-32 checksum.
// Optional horizontal-blanking check is enabled by defining HBLANK_CHECK_EN.
//
// state      | meaning
// S_SYNC     | after reset, waiting for frame_valid low so we never start mid-frame
// S_WAIT     | between frames, waiting for frame_valid high
// S_ACTIVE   | inside a frame, summing pixels and checking line lengths
// S_DONE     | one cycle: publish frame result, count frame, raise irq on error
module video_stream_monitor #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int HBLANK_MIN = 160,
    parameter int CNT_W      = 12
) (
    input  logic                  p_clk,
    input  logic                  p_reset,
    video_stream_monitor_if.slave vid,
    input  logic                  irq_ack,
    input  logic                  clear,
    output logic                  frame_done,
    output logic [31:0]           frame_checksum,
    output logic                  frame_ok,
    output logic [15:0]           frame_count,
    output logic                  err_line_len,
    output logic                  err_line_count,
    output logic                  err_protocol,
    output logic                  err_hblank,
    output logic                  irq
);

    typedef enum logic [1:0] {
        S_SYNC   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACTIVE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WIDTH_C  = CNT_W'(IMG_WIDTH);
    localparam logic [CNT_W-1:0] HEIGHT_C = CNT_W'(IMG_HEIGHT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t           state_q, state_d;
    logic [15:0]      sum_a_q, sum_a_d;
    logic [15:0]      sum_b_q, sum_b_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic             lv_q, lv_d;
    logic             fe_len_q, fe_len_d;
    logic             fe_proto_q, fe_proto_d;
    logic             fe_hb_q, fe_hb_d;
    logic             done_q, done_d;
    logic [31:0]      cksum_q, cksum_d;
    logic             ok_q, ok_d;
    logic [15:0]      count_q, count_d;
    logic             e_len_q, e_len_d;
    logic             e_lc_q, e_lc_d;
    logic             e_proto_q, e_proto_d;
    logic             e_hb_q, e_hb_d;
    logic             irq_q, irq_d;

`ifdef HBLANK_CHECK_EN
    localparam logic [CNT_W-1:0] HBLANK_C = CNT_W'(HBLANK_MIN);
    logic [CNT_W-1:0] blank_cnt_q, blank_cnt_d;
`else
    logic unused_hblank_cfg;
    assign unused_hblank_cfg = (HBLANK_MIN != 0);
`endif

    logic start, in_frame, pix_valid, line_end, lc_err, frame_good;

    always_comb begin
        state_d    = state_q;
        sum_a_d    = sum_a_q;
        sum_b_d    = sum_b_q;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        lv_d       = 1'b0;
        fe_len_d   = fe_len_q;
        fe_proto_d = fe_proto_q;
        fe_hb_d    = fe_hb_q;
        done_d     = 1'b0;
        cksum_d    = cksum_q;
        ok_d       = ok_q;
        count_d    = count_q;
        e_len_d    = e_len_q;
        e_lc_d     = e_lc_q;
        e_proto_d  = e_proto_q;
        e_hb_d     = e_hb_q;
        irq_d      = irq_q;
        lc_err     = 1'b0;
        frame_good = 1'b0;
`ifdef HBLANK_CHECK_EN
        blank_cnt_d = blank_cnt_q;
`endif

        // clear is applied first so detections in this same cycle survive it
        if (clear) begin
            e_len_d   = 1'b0;
            e_lc_d    = 1'b0;
            e_proto_d = 1'b0;
            e_hb_d    = 1'b0;
            count_d   = 16'd0;
        end
        if (irq_ack) begin
            irq_d = 1'b0;
        end

        // Frame context is zeroed while idle, so a first pixel on the entry cycle sums from zero
        if (state_q == S_WAIT) begin
            sum_a_d    = 16'd0;
            sum_b_d    = 16'd0;
            pix_cnt_d  = '0;
            line_cnt_d = '0;
            fe_len_d   = 1'b0;
            fe_proto_d = 1'b0;
            fe_hb_d    = 1'b0;
`ifdef HBLANK_CHECK_EN
            blank_cnt_d = '0;
`endif
        end

        start     = (state_q == S_WAIT) && vid.frame_valid;
        in_frame  = start || (state_q == S_ACTIVE);
        pix_valid = in_frame && vid.frame_valid && vid.line_valid;
        line_end  = (state_q == S_ACTIVE) && lv_q && !pix_valid;
        lv_d      = pix_valid;

        if (pix_valid) begin
            sum_a_d   = sum_a_d + {8'd0, vid.pixel_in};
            sum_b_d   = sum_b_d + sum_a_d;
            pix_cnt_d = sat_inc(pix_cnt_d);
        end

        if (line_end) begin
            line_cnt_d = sat_inc(line_cnt_d);
            if (pix_cnt_d != WIDTH_C) begin
                fe_len_d = 1'b1;
                e_len_d  = 1'b1;
            end
            pix_cnt_d = '0;
        end

        if (((state_q == S_WAIT) || (state_q == S_ACTIVE)) && !vid.frame_valid && vid.line_valid) begin
            e_proto_d = 1'b1;
            if (state_q == S_ACTIVE) begin
                fe_proto_d = 1'b1;
            end
        end

`ifdef HBLANK_CHECK_EN
        if ((state_q == S_ACTIVE) && vid.frame_valid && !vid.line_valid) begin
            if (line_end) begin
                blank_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (line_cnt_q != '0) begin
                blank_cnt_d = sat_inc(blank_cnt_d);
            end
        end
        if ((state_q == S_ACTIVE) && pix_valid && !lv_q && (line_cnt_q != '0)) begin
            if (blank_cnt_q < HBLANK_C) begin
                fe_hb_d = 1'b1;
                e_hb_d  = 1'b1;
            end
            blank_cnt_d = '0;
        end
`endif

        unique case (state_q)
            S_SYNC: begin
                if (!vid.frame_valid) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (vid.frame_valid) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (!vid.frame_valid) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                lc_err     = (line_cnt_q != HEIGHT_C);
                frame_good = !(fe_len_q || fe_proto_q || fe_hb_q || lc_err);
                done_d     = 1'b1;
                cksum_d    = {sum_b_q, sum_a_q};
                ok_d       = frame_good;
                count_d    = count_d + 16'd1;
                e_len_d    = e_len_d   | fe_len_q;
                e_proto_d  = e_proto_d | fe_proto_q;
                e_hb_d     = e_hb_d    | fe_hb_q;
                e_lc_d     = e_lc_d    | lc_err;
                if (!frame_good) begin
                    irq_d = 1'b1;
                end
                state_d = S_WAIT;
            end
            default: state_d = S_SYNC;
        endcase
    end

    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            state_q    <= S_SYNC;
            sum_a_q    <= 16'd0;
            sum_b_q    <= 16'd0;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            lv_q       <= 1'b0;
            fe_len_q   <= 1'b0;
            fe_proto_q <= 1'b0;
            fe_hb_q    <= 1'b0;
            done_q     <= 1'b0;
            cksum_q    <= 32'd0;
            ok_q       <= 1'b0;
            count_q    <= 16'd0;
            e_len_q    <= 1'b0;
            e_lc_q     <= 1'b0;
            e_proto_q  <= 1'b0;
            e_hb_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_a_q    <= sum_a_d;
            sum_b_q    <= sum_b_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            lv_q       <= lv_d;
            fe_len_q   <= fe_len_d;
            fe_proto_q <= fe_proto_d;
            fe_hb_q    <= fe_hb_d;
            done_q     <= done_d;
            cksum_q    <= cksum_d;
            ok_q       <= ok_d;
            count_q    <= count_d;
            e_len_q    <= e_len_d;
            e_lc_q     <= e_lc_d;
            e_proto_q  <= e_proto_d;
            e_hb_q     <= e_hb_d;
            irq_q      <= irq_d;
        end
    end

`ifdef HBLANK_CHECK_EN
    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            blank_cnt_q <= '0;
        end else begin
            blank_cnt_q <= blank_cnt_d;
        end
    end
    assign err_hblank = e_hb_q;
`else
    assign err_hblank = 1'b0;
`endif

    assign frame_done     = done_q;
    assign frame_checksum = cksum_q;
    assign frame_ok       = ok_q;
    assign frame_count    = count_q;
    assign err_line_len   = e_len_q;
    assign err_line_count = e_lc_q;
    assign err_protocol   = e_proto_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_video_stream_monitor.sv
// Directed bench for video_stream_monitor with a 4x2 image and a 2-cycle minimum blanking gap.
module tb_video_stream_monitor;

    logic        p_clk = 1'b0;
    logic        p_reset;
    logic        irq_ack;
    logic        clear;
    logic        frame_done;
    logic [31:0] frame_checksum;
    logic        frame_ok;
    logic [15:0] frame_count;
    logic        err_line_len;
    logic        err_line_count;
    logic        err_protocol;
    logic        err_hblank;
    logic        irq;

    int errors = 0;
    int checks = 0;
    int lat;
    logic seen;

    video_stream_monitor_if vid ();

    video_stream_monitor #(
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (2),
        .HBLANK_MIN (2),
        .CNT_W      (12)
    ) dut (
        .p_clk          (p_clk),
        .p_reset        (p_reset),
        .vid            (vid),
        .irq_ack        (irq_ack),
        .clear          (clear),
        .frame_done     (frame_done),
        .frame_checksum (frame_checksum),
        .frame_ok       (frame_ok),
        .frame_count    (frame_count),
        .err_line_len   (err_line_len),
        .err_line_count (err_line_count),
        .err_protocol   (err_protocol),
        .err_hblank     (err_hblank),
        .irq            (irq)
    );

    always #5 p_clk = ~p_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at a falling edge; the task returns at the next falling edge
    task automatic drive(input logic fv, input logic lv, input logic [7:0] px);
        vid.frame_valid = fv;
        vid.line_valid  = lv;
        vid.pixel_in    = px;
        @(negedge p_clk);
    endtask

    task automatic send_line(input int n, input int gap);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 8'd1);
        for (int i = 0; i < gap; i++) drive(1'b1, 1'b0, 8'd0);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 8'd0);
            cycles++;
            if (frame_done) break;
        end
        if (!frame_done) cycles = 99;
    endtask

    initial begin
        p_reset = 1'b1;
        irq_ack = 1'b0;
        clear   = 1'b0;
        vid.frame_valid = 1'b0;
        vid.line_valid  = 1'b0;
        vid.pixel_in    = 8'd0;
        @(negedge p_clk);
        @(negedge p_clk);

        check("rst_done",   {31'd0, frame_done}, 32'd0);
        check("rst_cksum",  frame_checksum, 32'd0);
        check("rst_ok",     {31'd0, frame_ok}, 32'd0);
        check("rst_count",  {16'd0, frame_count}, 32'd0);
        check("rst_errs",   {28'd0, err_line_len, err_line_count, err_protocol, err_hblank}, 32'd0);
        check("rst_irq",    {31'd0, irq}, 32'd0);

        p_reset = 1'b0;
        drive(1'b0, 1'b0, 8'd0);
        drive(1'b0, 1'b0, 8'd0);

        // good frame
        drive(1'b1, 1'b0, 8'd0);
        send_line(4, 2);
        send_line(4, 0);
        wait_done(lat);
        check("good_latency", lat, 32'd2);
        check("good_cksum",   frame_checksum, 32'h0024_0008);
        check("good_ok",      {31'd0, frame_ok}, 32'd1);
        check("good_count",   {16'd0, frame_count}, 32'd1);
        check("good_irq",     {31'd0, irq}, 32'd0);
        check("good_errs",    {28'd0, err_line_len, err_line_count, err_protocol, err_hblank}, 32'd0);
        drive(1'b0, 1'b0, 8'd0);
        check("done_pulse",   {31'd0, frame_done}, 32'd0);

        // short first line
        drive(1'b1, 1'b0, 8'd0);
        send_line(3, 2);
        send_line(4, 0);
        wait_done(lat);
        check("len_seen",  lat, 32'd2);
        check("len_err",   {31'd0, err_line_len}, 32'd1);
        check("len_ok",    {31'd0, frame_ok}, 32'd0);
        check("len_irq",   {31'd0, irq}, 32'd1);
        check("len_cksum", frame_checksum, 32'h001c_0007);
        check("len_count", {16'd0, frame_count}, 32'd2);
        irq_ack = 1'b1;
        drive(1'b0, 1'b0, 8'd0);
        irq_ack = 1'b0;
        check("ack_irq",    {31'd0, irq}, 32'd0);
        check("ack_sticky", {31'd0, err_line_len}, 32'd1);
        clear = 1'b1;
        drive(1'b0, 1'b0, 8'd0);
        clear = 1'b0;
        check("clr_err",   {31'd0, err_line_len}, 32'd0);
        check("clr_count", {16'd0, frame_count}, 32'd0);

        // three lines instead of two
        drive(1'b1, 1'b0, 8'd0);
        send_line(4, 2);
        send_line(4, 2);
        send_line(4, 0);
        wait_done(lat);
        check("lc_seen",  lat, 32'd2);
        check("lc_err",   {31'd0, err_line_count}, 32'd1);
        check("lc_ok",    {31'd0, frame_ok}, 32'd0);
        check("lc_cksum", frame_checksum, 32'h004e_000c);
        check("lc_count", {16'd0, frame_count}, 32'd1);
        irq_ack = 1'b1;
        drive(1'b0, 1'b0, 8'd0);
        irq_ack = 1'b0;
        drive(1'b1, 1'b0, 8'd0);
        send_line(4, 2);
        send_line(4, 0);
        wait_done(lat);
        check("lc2_ok",     {31'd0, frame_ok}, 32'd1);
        check("lc2_sticky", {31'd0, err_line_count}, 32'd1);
        check("lc2_count",  {16'd0, frame_count}, 32'd2);
        check("lc2_irq",    {31'd0, irq}, 32'd0);

        // reset mid-line, released while frame_valid is still high
        drive(1'b1, 1'b0, 8'd0);
        drive(1'b1, 1'b1, 8'd1);
        drive(1'b1, 1'b1, 8'd1);
        p_reset = 1'b1;
        drive(1'b1, 1'b1, 8'd1);
        check("mrst_count", {16'd0, frame_count}, 32'd0);
        check("mrst_sticky", {31'd0, err_line_count}, 32'd0);
        p_reset = 1'b0;
        drive(1'b1, 1'b1, 8'd1);
        drive(1'b1, 1'b0, 8'd0);
        drive(1'b1, 1'b0, 8'd0);
        send_line(4, 0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 8'd0);
            if (frame_done) seen = 1'b1;
        end
        check("mrst_no_done", {31'd0, seen}, 32'd0);
        drive(1'b1, 1'b0, 8'd0);
        send_line(4, 2);
        send_line(4, 0);
        wait_done(lat);
        check("mrst_seen",  lat, 32'd2);
        check("mrst_ok",    {31'd0, frame_ok}, 32'd1);
        check("mrst_count2", {16'd0, frame_count}, 32'd1);

        // frame_valid drops while line_valid is high
        drive(1'b1, 1'b0, 8'd0);
        send_line(4, 2);
        send_line(3, 0);
        drive(1'b0, 1'b1, 8'd1);
        check("proto_err", {31'd0, err_protocol}, 32'd1);
        wait_done(lat);
        check("proto_seen",  lat, 32'd1);
        check("proto_ok",    {31'd0, frame_ok}, 32'd0);
        check("proto_cksum", frame_checksum, 32'h001c_0007);
        check("proto_len",   {31'd0, err_line_len}, 32'd1);
        check("proto_count", {16'd0, frame_count}, 32'd2);

        irq_ack = 1'b1;
        clear   = 1'b1;
        drive(1'b0, 1'b0, 8'd0);
        irq_ack = 1'b0;
        clear   = 1'b0;

        // one-cycle blanking gap
        drive(1'b1, 1'b0, 8'd0);
        send_line(4, 1);
        send_line(4, 0);
        wait_done(lat);
        check("hb_seen", lat, 32'd2);
`ifdef HBLANK_CHECK_EN
        check("hb_err", {31'd0, err_hblank}, 32'd1);
        check("hb_ok",  {31'd0, frame_ok}, 32'd0);
`else
        check("hb_err", {31'd0, err_hblank}, 32'd0);
        check("hb_ok",  {31'd0, frame_ok}, 32'd1);
`endif
        check("hb_count", {16'd0, frame_count}, 32'd1);

        irq_ack = 1'b1;
        drive(1'b0, 1'b0, 8'd0);
        irq_ack = 1'b0;
        check("pre_irq", {31'd0, irq}, 32'd0);

        // clear and irq_ack arriving in the DONE cycle of a failing frame
        drive(1'b1, 1'b0, 8'd0);
        send_line(3, 2);
        send_line(4, 0);
        drive(1'b0, 1'b0, 8'd0);
        clear   = 1'b1;
        irq_ack = 1'b1;
        drive(1'b0, 1'b0, 8'd0);
        clear   = 1'b0;
        irq_ack = 1'b0;
        check("cd_done",  {31'd0, frame_done}, 32'd1);
        check("cd_count", {16'd0, frame_count}, 32'd1);
        check("cd_len",   {31'd0, err_line_len}, 32'd1);
        check("cd_ok",    {31'd0, frame_ok}, 32'd0);
        check("cd_irq",   {31'd0, irq}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
